// File: rtl/frogger_player_ctrl.sv
// frogger_player_ctrl: grid-based Frogger player controller.
// Edge-detects the debounced move switches, moves the frog one cell per accepted
// edge (priority Up > Down > Left > Right, optional cooldown), runs the
// IDLE / ALIVE / DYING / GAME_OVER life cycle, keeps score and lives, and
// produces the registered sprite pixel enable for the VGA compositor.
// Optional build macro: FROGGER_WRAP_X_EN -- horizontal moves wrap around the
// grid instead of clamping at the left/right edges (Y always clamps).
module frogger_player_ctrl #(
    parameter int GRID_W       = 20,
    parameter int GRID_H       = 15,
    parameter int START_X      = 10,
    parameter int START_Y      = 14,
    parameter int COORD_W      = 6,
    parameter int SCORE_W      = 7,
    parameter int LIVES        = 3,
    parameter int COOLDOWN     = 0,
    parameter int DEATH_CYCLES = 25000000
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Up_Mvt,
    input  logic               i_Down_Mvt,
    input  logic               i_Left_Mvt,
    input  logic               i_Right_Mvt,
    input  logic               i_Game_Active,
    input  logic               i_Hazard,
    input  logic [COORD_W-1:0] i_Col_Count_Div,
    input  logic [COORD_W-1:0] i_Row_Count_Div,
    output logic               o_Draw_Frogger,
    output logic [COORD_W-1:0] o_Frogger_X,
    output logic [COORD_W-1:0] o_Frogger_Y,
    output logic [SCORE_W-1:0] o_Score,
    output logic [2:0]         o_Lives,
    output logic               o_Goal_Pulse,
    output logic               o_Game_Over
);

    localparam int DC_W = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;
    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [COORD_W-1:0] X_START    = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y_START    = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] C_ONE      = COORD_W'(1);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(COOLDOWN);
    localparam logic [DC_W-1:0]    DC_LAST    = DC_W'(DEATH_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

`ifdef FROGGER_WRAP_X_EN
    localparam bit WRAP_X = 1'b1;
`else
    localparam bit WRAP_X = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIVE,
        ST_DYING,
        ST_GAME_OVER
    } state_t;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [2:0]           lives_q, lives_d;
    logic [CD_W-1:0]      cool_q, cool_d;
    logic [DC_W-1:0]      death_q, death_d;
    logic                 goal_q, goal_d;
    logic                 draw_q, draw_d;
    logic                 up_q, down_q, left_q, right_q, active_q;
    logic                 game_over;

    logic                 up_edge, down_edge, left_edge, right_edge, active_rise;
    logic                 at_goal, death_done, move_ok;
    logic                 mv_any;
    logic [COORD_W-1:0]   mv_x, mv_y;

    assign up_edge     = i_Up_Mvt    & ~up_q;
    assign down_edge   = i_Down_Mvt  & ~down_q;
    assign left_edge   = i_Left_Mvt  & ~left_q;
    assign right_edge  = i_Right_Mvt & ~right_q;
    assign active_rise = i_Game_Active & ~active_q;
    assign at_goal     = (y_q == '0);
    assign death_done  = (death_q == DC_LAST);
    assign move_ok     = (cool_q == '0);

    // Input history for rising-edge detection of the switches and game enable.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            up_q     <= i_Up_Mvt;
            down_q   <= i_Down_Mvt;
            left_q   <= i_Left_Mvt;
            right_q  <= i_Right_Mvt;
            active_q <= i_Game_Active;
        end
    end

    // Candidate position for the highest-priority move edge, clamped or wrapped.
    // NOTE: every output gets a default first, so no path infers a latch.
    always_comb begin
        mv_any = 1'b0;
        mv_x   = x_q;
        mv_y   = y_q;
        if (up_edge) begin
            mv_any = 1'b1;
            if (y_q != '0) mv_y = y_q - C_ONE;
        end else if (down_edge) begin
            mv_any = 1'b1;
            if (y_q != Y_MAX) mv_y = y_q + C_ONE;
        end else if (left_edge) begin
            mv_any = 1'b1;
            if (x_q != '0)  mv_x = x_q - C_ONE;
            else if (WRAP_X) mv_x = X_MAX;
        end else if (right_edge) begin
            mv_any = 1'b1;
            if (x_q != X_MAX) mv_x = x_q + C_ONE;
            else if (WRAP_X)  mv_x = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: game enable drops win, then goal over hazard, death timer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_Game_Active) state_d = ST_ALIVE;
            end
            ST_ALIVE: begin
                if (!i_Game_Active)            state_d = ST_IDLE;
                else if (!at_goal && i_Hazard) state_d = ST_DYING;
            end
            ST_DYING: begin
                if (!i_Game_Active)  state_d = ST_IDLE;
                else if (death_done) state_d = (lives_q == '0) ? ST_GAME_OVER : ST_ALIVE;
            end
            ST_GAME_OVER: begin
                if (active_rise) state_d = ST_ALIVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: game-over flag and the pre-register sprite enable (blinks in DYING).
    always_comb begin
        game_over = (state_q == ST_GAME_OVER);
        draw_d    = 1'b0;
        if (i_Col_Count_Div == x_q && i_Row_Count_Div == y_q) begin
            unique case (state_q)
                ST_GAME_OVER: draw_d = 1'b0;
                ST_DYING:     draw_d = death_q[DC_W-1];
                default:      draw_d = 1'b1;
            endcase
        end
    end

    // Datapath next values: position, score, lives, cooldown and death timer.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        score_d = score_q;
        lives_d = lives_q;
        goal_d  = 1'b0;
        cool_d  = (cool_q != '0) ? cool_q - CD_W'(1) : '0;
        death_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                x_d = X_START;
                y_d = Y_START;
            end
            ST_ALIVE: begin
                if (!i_Game_Active) begin
                    x_d = X_START;
                    y_d = Y_START;
                end else if (at_goal) begin
                    score_d = (score_q != SCORE_MAX) ? score_q + SCORE_W'(1) : score_q;
                    goal_d  = 1'b1;
                    x_d     = X_START;
                    y_d     = Y_START;
                end else if (i_Hazard) begin
                    lives_d = (lives_q != '0) ? lives_q - 3'd1 : 3'd0;
                end else if (mv_any && move_ok) begin
                    x_d    = mv_x;
                    y_d    = mv_y;
                    cool_d = CD_LOAD;
                end
            end
            ST_DYING: begin
                if (!i_Game_Active) begin
                    x_d = X_START;
                    y_d = Y_START;
                end else if (death_done) begin
                    // With lives left the frog respawns; otherwise it stays where it died.
                    if (lives_q != '0) begin
                        x_d = X_START;
                        y_d = Y_START;
                    end
                end else begin
                    death_d = death_q + DC_W'(1);
                end
            end
            ST_GAME_OVER: begin
                if (active_rise) begin
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    x_d     = X_START;
                    y_d     = Y_START;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            x_q     <= X_START;
            y_q     <= Y_START;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            cool_q  <= '0;
            death_q <= '0;
            goal_q  <= 1'b0;
            draw_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            score_q <= score_d;
            lives_q <= lives_d;
            cool_q  <= cool_d;
            death_q <= death_d;
            goal_q  <= goal_d;
            draw_q  <= draw_d;
        end
    end

    assign o_Draw_Frogger = draw_q;
    assign o_Frogger_X    = x_q;
    assign o_Frogger_Y    = y_q;
    assign o_Score        = score_q;
    assign o_Lives        = lives_q;
    assign o_Goal_Pulse   = goal_q;
    assign o_Game_Over    = game_over;

endmodule

// File: doc/frogger_player_ctrl.md
Name: frogger_player_ctrl

Overview:
Parametrised player controller for the grid-based Frogger game. It generalises the first-generation frog controller with configurable grid size, start cell, score width, lives and move cooldown. It adds a life/death state machine driven by a hazard input and a goal pulse. It sits between the debounced switch inputs and the VGA sprite compositor, and feeds score and lives to the 7-segment/HUD logic.

Parameters:
GRID_W, 20, number of columns; legal X is 0..GRID_W-1
GRID_H, 15, number of rows; row 0 is the goal row, legal Y is 0..GRID_H-1
START_X, 10, respawn column
START_Y, 14, respawn row; must be less than GRID_H
COORD_W, 6, width of coordinate and divided-counter buses
SCORE_W, 7, score width
LIVES, 3, lives at reset and new game; 1..7
COOLDOWN, 0, clock cycles after an accepted move during which further moves are ignored
DEATH_CYCLES, 25000000, clock cycles spent in DYING

Ports:
i_Clk  in  1  system clock (25 MHz pixel clock)
i_Reset  in  1  asynchronous, active-high reset
i_Up_Mvt  in  1  move request Y-1 (debounced level)
i_Down_Mvt  in  1  move request Y+1
i_Left_Mvt  in  1  move request X-1
i_Right_Mvt  in  1  move request X+1
i_Game_Active  in  1  level; high = play enabled
i_Hazard  in  1  high when an obstacle occupies the frog cell (from the lane logic)
i_Col_Count_Div  in  COORD_W  current pixel column in grid units
i_Row_Count_Div  in  COORD_W  current pixel row in grid units
o_Draw_Frogger  out  1  frog pixel enable
o_Frogger_X  out  COORD_W  frog column
o_Frogger_Y  out  COORD_W  frog row
o_Score  out  SCORE_W  crossings completed
o_Lives  out  3  lives remaining
o_Goal_Pulse  out  1  one-cycle pulse per crossing
o_Game_Over  out  1  high in GAME_OVER

Behaviour:
- Reset (async assert, sync release): state IDLE; X=START_X, Y=START_Y; score 0; lives LIVES; draw, goal pulse and game over all 0; edge registers 0; cooldown 0.
- Edge detect: each input is registered once; a move request is input high while its register is low (rising edge). Only one move is accepted per cycle, priority Up > Down > Left > Right. Lower-priority edges in the same cycle are discarded.
- Move is accepted only in ALIVE with cooldown==0. After acceptance the cooldown loads COOLDOWN and decrements to 0.
- Bounds: a move past an edge is ignored. Y=0 with Up: no change. Y=GRID_H-1 with Down: no change. X=0 with Left and X=GRID_W-1 with Right: no change, unless the optional feature is enabled.
- Position updates one cycle after the input edge.
- States:
  - IDLE: frog at start. Go to ALIVE when i_Game_Active=1.
  - ALIVE: moves allowed.
    - Y==0: next cycle score+1 (saturates at all-ones), o_Goal_Pulse=1 for one cycle, frog returns to START_X/START_Y, stay ALIVE.
    - i_Hazard=1 and Y!=0: lives-1, go to DYING. If goal and hazard coincide, the goal wins.
  - DYING: position frozen; o_Draw_Frogger gated by the death counter MSB (blink). After DEATH_CYCLES: lives==0 goes to GAME_OVER, otherwise the frog respawns at start and returns to ALIVE.
  - GAME_OVER: o_Game_Over=1; frog frozen. A rising edge of i_Game_Active restores score 0, lives LIVES and start position, then goes to ALIVE.
- i_Game_Active low in ALIVE or DYING goes to IDLE. Score and lives are held; position returns to start.
- Draw: registered, 1-cycle latency. High when Col==X and Row==Y and state is not GAME_OVER (blink-gated in DYING).

Optional Feature:
FROGGER_WRAP_X_EN
- Defined: Left at X=0 goes to GRID_W-1; Right at X=GRID_W-1 goes to 0. Y is still clamped.
- Undefined: X is clamped as described in Behaviour.

Test Plan:
- Reset, i_Game_Active=1, one Up edge -> X=10, Y=13 after 1 cycle. A held Up level produces no further moves.
- Up, Down and Left edges in the same cycle -> only Y decrements. Left edge at X=0 -> X stays 0 (wrap build: X=19).
- 14 Up edges from Y=14 -> Y reaches 0, then o_Goal_Pulse for one cycle, score 1, frog at (10,14).
- Hazard at Y=7 -> lives 2, DYING with draw blinking, X/Y frozen under moves. After DEATH_CYCLES (bench value 8) the frog is at (10,14) and ALIVE.
- Three hazards -> lives 0, o_Game_Over=1. i_Game_Active toggle 0->1 -> score 0, lives 3, ALIVE.
- COOLDOWN=4: edges on consecutive cycles -> only first and one ≥5 cycles later accepted. Assert i_Reset mid-DYING -> all outputs return to reset values immediately.
